// File: rtl/sseg_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// sseg_share_arb_pkg
//   Shared definitions for blocks that time-share the 4-digit seven-segment
//   display: display word width, arbiter FSM state encoding, default slot
//   length and a small round-robin wrap helper.
// -----------------------------------------------------------------------------
package sseg_share_arb_pkg;

    // Width of the value shown on the display (4 hex digits).
    localparam int HEX_W = 16;

    // Default display slot: 0.5 s at a 100 MHz system clock.
    localparam int DEFAULT_HOLD_CYCLES = 50_000_000;

    // Arbiter FSM state encoding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // Next index after idx in a ring of n entries. Returns 0 for n == 1,
    // which keeps the round-robin pointer pinned for a single requester.
    function automatic int wrap_next(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/sseg_share_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// sseg_share_arb_rr_pick
//   Combinational round-robin picker. Scans req starting at rr_ptr and
//   wrapping modulo N; the first set bit wins.
//
//   Ports:
//     req     in   N       request vector
//     rr_ptr  in   PTR_W   highest-priority index for this scan (< N)
//     onehot  out  N       one-hot winner, zero when no request is set
//     index   out  PTR_W   binary winner index, zero when no request is set
//     any     out  1       at least one request is set
// -----------------------------------------------------------------------------
module sseg_share_arb_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     onehot,
    output logic [PTR_W-1:0] index,
    output logic             any
);

    always_comb begin
        logic found;
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            // Rotate the scan so that rr_ptr is examined first.
            j = int'(rr_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                index     = PTR_W'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/sseg_share_arb.sv
// -----------------------------------------------------------------------------
// sseg_share_arb
//   Shares the single 4-digit seven-segment display among NUM_REQ requesters.
//   Pending requests are arbitrated round-robin; the winner owns the display
//   for HOLD_CYCLES clocks, during which its req_data word is copied to
//   hex_digits every cycle. When the slot ends the owner gets a one-cycle ack
//   and the arbiter spends exactly one cycle in IDLE before the next grant.
//
//   Handshake: req[i] is a level request that the requester holds until it
//   sees ack[i]. grant[i] marks the current owner; ack[i] is a single-cycle
//   pulse in the cycle after the owner's last display cycle and never
//   overlaps grant. Dropping req during a slot does not shorten the slot.
//
//   Ports:
//     clk         in   1             system clock, rising edge
//     reset_n     in   1             asynchronous active-low reset
//     req         in   NUM_REQ       level request per requester
//     req_data    in   16*NUM_REQ    requester i value at [16*i+15:16*i]
//     hex_digits  out  16            value for sseg_top.hex_digits
//     grant       out  NUM_REQ       one-hot owner, zero in IDLE
//     ack         out  NUM_REQ       one-cycle pulse when the owner's slot ends
//     busy        out  1             high while in SHOW
//     state_dbg   out  1             current FSM state (ST_IDLE / ST_SHOW)
// -----------------------------------------------------------------------------
module sseg_share_arb
    import sseg_share_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int CNT_W       = 26
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [HEX_W*NUM_REQ-1:0] req_data,
    output logic [HEX_W-1:0]         hex_digits,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     busy,
    output logic                     state_dbg
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Last counter value of a slot.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    logic [HEX_W-1:0]   pick_data;
    logic [HEX_W-1:0]   owner_data;

    sseg_share_arb_rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .onehot (pick_onehot),
        .index  (pick_idx),
        .any    (pick_any)
    );

    // Data word of the requester about to be granted, and of the current
    // owner. Written as a compare-mux so the index never leaves the vector.
    always_comb begin
        pick_data  = '0;
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == PTR_W'(i)) begin
                pick_data = req_data[i*HEX_W +: HEX_W];
            end
            if (owner == PTR_W'(i)) begin
                owner_data = req_data[i*HEX_W +: HEX_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rr_ptr     <= '0;
            owner      <= '0;
            hex_digits <= '0;
            grant      <= '0;
            ack        <= '0;
            busy       <= 1'b0;
        end else begin
            // ack is a pulse: cleared every cycle unless a slot ends now.
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    // hex_digits keeps the previous owner's last value here.
                    if (pick_any) begin
                        state      <= ST_SHOW;
                        grant      <= pick_onehot;
                        owner      <= pick_idx;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        hex_digits <= pick_data;
                    end
                end
                ST_SHOW: begin
                    // Track the owner's live value even if it dropped req.
                    hex_digits <= owner_data;
                    if (cnt == CNT_LAST) begin
                        state  <= ST_IDLE;
                        ack    <= grant;
                        grant  <= '0;
                        busy   <= 1'b0;
                        cnt    <= '0;
                        // The finishing owner becomes lowest priority.
                        rr_ptr <= PTR_W'(wrap_next(int'(owner), NUM_REQ));
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_sseg_share_arb.sv
module tb_sseg_share_arb;

  // Two instances share clock and reset: dut_a with 4-cycle slots, dut_b with
  // 1-cycle slots.
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_a, req_b;
  logic [63:0] data_a, data_b;
  logic [15:0] hex_a, hex_b;
  logic [3:0]  grant_a, grant_b, ack_a, ack_b;
  logic        busy_a, busy_b, st_a, st_b;

  int checks = 0;
  int errors = 0;

  // Expected slot record: {ack[3:0], slot_len[7:0], last_hex[15:0]}
  logic [27:0] exp_q[$];
  logic [27:0] exp_b_q[$];

  int          len_a = 0, len_b = 0;
  logic [15:0] last_hex_a = '0, last_hex_b = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sseg_share_arb #(.NUM_REQ(4), .HOLD_CYCLES(4), .CNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .req_data(data_a),
    .hex_digits(hex_a), .grant(grant_a), .ack(ack_a), .busy(busy_a),
    .state_dbg(st_a)
  );

  sseg_share_arb #(.NUM_REQ(4), .HOLD_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .req_data(data_b),
    .hex_digits(hex_b), .grant(grant_b), .ack(ack_b), .busy(busy_b),
    .state_dbg(st_b)
  );

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_ack_a(input int max);
    for (int k = 0; k < max; k++) begin
      tick();
      if (ack_a != 4'b0) break;
    end
    if (ack_a == 4'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_ack_a: got no ack, required one within %0d cycles", max);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [27:0] e;
    if (!reset_n) begin
      len_a = 0;
      len_b = 0;
    end else begin
      chk("a_grant_onehot0", 32'($onehot0(grant_a)), 32'd1);
      chk("a_ack_onehot0", 32'($onehot0(ack_a)), 32'd1);
      chk("a_ack_grant_overlap", 32'(ack_a & grant_a), 32'd0);
      if (ack_a != 4'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_ack: got ack %b, required none", ack_a);
        end else begin
          e = exp_q.pop_front();
          chk("a_ack", 32'(ack_a), 32'(e[27:24]));
          chk("a_slot_len", 32'(len_a), 32'(e[23:16]));
          chk("a_slot_hex", 32'(last_hex_a), 32'(e[15:0]));
        end
        len_a = 0;
      end
      if (grant_a != 4'b0) begin
        len_a++;
        last_hex_a = hex_a;
      end

      chk("b_ack_grant_overlap", 32'(ack_b & grant_b), 32'd0);
      if (ack_b != 4'b0) begin
        if (exp_b_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_ack: got ack %b, required none", ack_b);
        end else begin
          e = exp_b_q.pop_front();
          chk("b_ack", 32'(ack_b), 32'(e[27:24]));
          chk("b_slot_len", 32'(len_b), 32'(e[23:16]));
          chk("b_slot_hex", 32'(last_hex_b), 32'(e[15:0]));
        end
        len_b = 0;
      end
      if (grant_b != 4'b0) begin
        len_b++;
        last_hex_b = hex_b;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [3:0] order[4];
    order[0] = 4'b0010;
    order[1] = 4'b0100;
    order[2] = 4'b1000;
    order[3] = 4'b0001;

    reset_n = 1'b0;
    req_a   = 4'hF;
    req_b   = 4'h0;
    data_a  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    data_b  = {16'h0000, 16'h0000, 16'hBBBB, 16'hAAAA};

    // Reset held with all requests pending.
    repeat (3) tick();
    chk("rst_hex", 32'(hex_a), 32'h0);
    chk("rst_grant", 32'(grant_a), 32'h0);
    chk("rst_ack", 32'(ack_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_state", 32'(st_a), 32'h0);

    // Fairness: req=F held gives 0,1,2,3,0 with 4-cycle slots.
    exp_q.push_back({4'b0001, 8'd4, 16'h1111});
    exp_q.push_back({4'b0010, 8'd4, 16'h2222});
    exp_q.push_back({4'b0100, 8'd4, 16'h3333});
    exp_q.push_back({4'b1000, 8'd4, 16'h4444});
    exp_q.push_back({4'b0001, 8'd4, 16'h1111});
    reset_n = 1'b1;
    tick();
    chk("latency_grant", 32'(grant_a), 32'b0001);
    chk("latency_busy", 32'(busy_a), 32'h1);
    for (int n = 0; n < 4; n++) begin
      wait_ack_a(20);
      chk("gap_grant", 32'(grant_a), 32'h0);
      chk("gap_busy", 32'(busy_a), 32'h0);
      if (n == 3) req_a = 4'b0001;
      tick();
      chk("fair_grant", 32'(grant_a), 32'(order[n]));
    end
    // Owner 0 drops req at cnt=1; slot must still run to its end.
    tick();
    req_a = 4'b0000;
    wait_ack_a(20);
    chk("drop_ack", 32'(ack_a), 32'b0001);
    tick();
    chk("idle_grant", 32'(grant_a), 32'h0);
    chk("idle_busy", 32'(busy_a), 32'h0);

    // Single requester 2 with BEEF.
    data_a[47:32] = 16'hBEEF;
    exp_q.push_back({4'b0100, 8'd4, 16'hBEEF});
    req_a = 4'b0100;
    tick();
    chk("single_grant", 32'(grant_a), 32'b0100);
    chk("single_hex", 32'(hex_a), 32'hBEEF);
    wait_ack_a(20);
    req_a = 4'b0000;
    chk("single_ack", 32'(ack_a), 32'b0100);
    tick();
    chk("held_hex", 32'(hex_a), 32'hBEEF);
    chk("held_grant", 32'(grant_a), 32'h0);

    // Live update of owner 1; other data and requests ignored mid-slot.
    data_a[31:16] = 16'h0001;
    exp_q.push_back({4'b0010, 8'd4, 16'h0002});
    req_a = 4'b0010;
    tick();
    chk("live_grant", 32'(grant_a), 32'b0010);
    chk("live_hex0", 32'(hex_a), 32'h0001);
    tick();
    data_a[31:16] = 16'h0002;
    data_a[15:0]  = 16'h9999;
    req_a = 4'b1010;
    tick();
    chk("live_hex1", 32'(hex_a), 32'h0002);
    chk("live_owner_kept", 32'(grant_a), 32'b0010);
    wait_ack_a(20);
    req_a = 4'b0000;
    tick();
    chk("live_after_grant", 32'(grant_a), 32'h0);

    // Reset in the middle of a slot: no ack may follow.
    req_a = 4'b0100;
    tick();
    chk("mid_grant", 32'(grant_a), 32'b0100);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_hex", 32'(hex_a), 32'h0);
    chk("mid_rst_grant", 32'(grant_a), 32'h0);
    chk("mid_rst_busy", 32'(busy_a), 32'h0);
    chk("mid_rst_ack", 32'(ack_a), 32'h0);
    req_a = 4'b0000;
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_grant", 32'(grant_a), 32'h0);

    // HOLD_CYCLES=1: grant and ack alternate between requesters 0 and 1.
    exp_b_q.push_back({4'b0001, 8'd1, 16'hAAAA});
    exp_b_q.push_back({4'b0010, 8'd1, 16'hBBBB});
    exp_b_q.push_back({4'b0001, 8'd1, 16'hAAAA});
    exp_b_q.push_back({4'b0010, 8'd1, 16'hBBBB});
    req_b = 4'b0011;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("h1_grant", 32'(grant_b), (n % 2 == 1) ? 32'b0010 : 32'b0001);
      chk("h1_grant_ack", 32'(ack_b), 32'h0);
      tick();
      chk("h1_ack", 32'(ack_b), (n % 2 == 1) ? 32'b0010 : 32'b0001);
      chk("h1_ack_grant", 32'(grant_b), 32'h0);
      if (n == 3) req_b = 4'b0000;
    end
    repeat (3) tick();

    chk("a_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
